// File: rtl/key_sw_capture.sv
// Synchronises, debounces and packs the board's push-buttons and slide switches
// into a 32-bit PIO input word, with sticky key-press flags and an interrupt.
module key_sw_capture #(
  parameter int N_KEYS          = 3,
  parameter int N_SW            = 18,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic              CLOCK_50,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_SW-1:0]   sw,
  input  logic              ack,
  input  logic [N_KEYS-1:0] ack_mask,
  output logic [31:0]       pio_data,
  output logic              irq
);

  localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] r_key_s1, r_key_s2, r_key_smp, r_key_deb, r_edge;
  logic [N_SW-1:0]   r_sw_s1, r_sw_s2, r_sw_smp, r_sw_deb;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_pio;
  logic              r_irq;

  logic              w_tick;
  logic [N_KEYS-1:0] w_key_sync, w_key_deb_nxt, w_key_rise, w_ack_clr, w_edge_nxt;
  logic [N_SW-1:0]   w_sw_deb_nxt;
  logic [31:0]       w_pio_nxt;

  assign w_tick     = (r_cnt == TICK_MAX);
  assign w_key_sync = ~r_key_s2;

  // Debounce, edge-flag and output-word next-state logic
  always_comb begin
    // deb takes the synchronised value only when it agrees with the previous sample
    w_key_deb_nxt = r_key_deb;
    w_sw_deb_nxt  = r_sw_deb;
    w_key_rise    = '0;
    if (w_tick) begin
      w_key_deb_nxt = (w_key_sync & r_key_smp) | (r_key_deb & (w_key_sync | r_key_smp));
      w_sw_deb_nxt  = (r_sw_s2 & r_sw_smp) | (r_sw_deb & (r_sw_s2 | r_sw_smp));
      w_key_rise    = w_key_deb_nxt & ~r_key_deb;
    end else begin
      w_key_rise    = '0;
    end

    if (ack) begin
      w_ack_clr = ack_mask;
    end else begin
      w_ack_clr = '0;
    end
    // Set is OR-ed in after the clear so a press coinciding with ack is kept
    w_edge_nxt = (r_edge & ~w_ack_clr) | w_key_rise;

    w_pio_nxt = 32'h0000_0000;
    w_pio_nxt[N_SW-1:0]               = r_sw_deb;
    w_pio_nxt[N_SW +: N_KEYS]         = r_key_deb;
    w_pio_nxt[N_SW + N_KEYS +: N_KEYS] = r_edge;
  end

  // Synchroniser, tick counter, debounce state, flags and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (!reset_reset_n) begin
      r_key_s1  <= '0;
      r_key_s2  <= '0;
      r_sw_s1   <= '0;
      r_sw_s2   <= '0;
      r_key_smp <= '0;
      r_sw_smp  <= '0;
      r_key_deb <= '0;
      r_sw_deb  <= '0;
      r_edge    <= '0;
      r_cnt     <= '0;
      r_pio     <= 32'h0000_0000;
      r_irq     <= 1'b0;
    end else begin
      r_key_s1  <= key_n;
      r_key_s2  <= r_key_s1;
      r_sw_s1   <= sw;
      r_sw_s2   <= r_sw_s1;
      if (w_tick) begin
        r_cnt     <= '0;
        r_key_smp <= w_key_sync;
        r_sw_smp  <= r_sw_s2;
      end else begin
        r_cnt     <= r_cnt + CNT_W'(1);
      end
      r_key_deb <= w_key_deb_nxt;
      r_sw_deb  <= w_sw_deb_nxt;
      r_edge    <= w_edge_nxt;
      r_irq     <= |w_edge_nxt;
      r_pio     <= w_pio_nxt;
    end
  end

  assign pio_data = r_pio;
  assign irq      = r_irq;

endmodule

// File: tb/tb_key_sw_capture.sv
// Directed bench for key_sw_capture with a 4-clock debounce tick; vectors start
// on tick-aligned cycles so every expected word is a fixed hand-computed value.
module tb_key_sw_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  key_n;
  logic [17:0] sw;
  logic        ack;
  logic [2:0]  ack_mask;
  logic [31:0] pio_data;
  logic        irq;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  key_sw_capture #(
    .N_KEYS(3), .N_SW(18), .DEBOUNCE_CYCLES(4), .CNT_W(3)
  ) dut (
    .CLOCK_50(clk), .reset_reset_n(rst_n), .key_n(key_n), .sw(sw),
    .ack(ack), .ack_mask(ack_mask), .pio_data(pio_data), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  key_n;
    logic [17:0] sw;
    logic        ack;
    logic [2:0]  mask;
    int          ncyc;
    logic [31:0] pio;
    logic        irq;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic align();
    while (cyc % 4 != 0) step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  vec_t vt[5];

  initial begin
    logic done;
    vt[0] = '{3'b101, 18'h2A5A5, 1'b0, 3'b000, 12, 32'h004A_A5A5, 1'b1};
    vt[1] = '{3'b111, 18'h2A5A5, 1'b0, 3'b000, 12, 32'h0042_A5A5, 1'b1};
    vt[2] = '{3'b111, 18'h15A5A, 1'b0, 3'b000, 12, 32'h0041_5A5A, 1'b1};
    vt[3] = '{3'b111, 18'h15A5A, 1'b1, 3'b010, 12, 32'h0001_5A5A, 1'b0};
    vt[4] = '{3'b010, 18'h00000, 1'b0, 3'b000, 12, 32'h00B4_0000, 1'b1};

    rst_n = 1'b0; key_n = 3'b111; sw = 18'h0; ack = 1'b0; ack_mask = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pio", pio_data, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    cyc = 0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_pio", pio_data, 32'h0);
      chk("idle_irq", {31'h0, irq}, 32'h0);
    end

    // Switch word appears within 2+8+1 cycles
    sw = 18'h2A5A5;
    done = 1'b0;
    for (int k = 0; k < 11 && !done; k++) begin
      step();
      if (pio_data[17:0] == 18'h2A5A5) done = 1'b1;
    end
    chk("sw_latency", {31'h0, done}, 32'h1);
    chk("sw_upper", {18'h0, pio_data[31:18]}, 32'h0);
    chk("sw_irq", {31'h0, irq}, 32'h0);
    align();

    // 3-cycle glitch on key 0 seen by only one tick
    for (int i = 0; i < 12; i++) begin
      if (i == 0) key_n = 3'b110;
      if (i == 3) key_n = 3'b111;
      step();
      chk("glitch_pio", pio_data, 32'h0002_A5A5);
      chk("glitch_irq", {31'h0, irq}, 32'h0);
    end

    for (int v = 0; v < 5; v++) begin
      key_n = vt[v].key_n; sw = vt[v].sw; ack = vt[v].ack; ack_mask = vt[v].mask;
      step();
      ack = 1'b0; ack_mask = 3'b000;
      run(vt[v].ncyc - 1);
      chk($sformatf("vec%0d_pio", v), pio_data, vt[v].pio);
      chk($sformatf("vec%0d_irq", v), {31'h0, irq}, {31'h0, vt[v].irq});
    end

    // Masked clears: edge=101, keys 0 and 2 still held
    ack = 1'b1; ack_mask = 3'b001; step();
    chk("ack001_irq", {31'h0, irq}, 32'h1);
    ack = 1'b0; ack_mask = 3'b000; step();
    chk("ack001_pio", pio_data, 32'h0094_0000);
    ack = 1'b1; ack_mask = 3'b100; step();
    chk("ack100_irq", {31'h0, irq}, 32'h0);
    ack = 1'b0; ack_mask = 3'b000; step();
    chk("ack100_pio", pio_data, 32'h0014_0000);
    ack = 1'b1; ack_mask = 3'b111; run(3);
    chk("ack_none_irq", {31'h0, irq}, 32'h0);
    ack = 1'b0; ack_mask = 3'b000; step();
    chk("ack_none_pio", pio_data, 32'h0014_0000);

    key_n = 3'b111;
    align();
    run(12);
    chk("release_pio", pio_data, 32'h0);

    // Key-2 press accepted on the same edge as its ack: set wins
    key_n = 3'b011;
    run(7);
    ack = 1'b1; ack_mask = 3'b100; step();
    chk("setwins_irq", {31'h0, irq}, 32'h1);
    ack = 1'b0; ack_mask = 3'b000; step();
    chk("setwins_pio", pio_data, 32'h0090_0000);

    // Reset mid-count clears everything on that edge
    rst_n = 1'b0; step();
    chk("midrst_pio", pio_data, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    rst_n = 1'b1;
    cyc = 0;
    run(3);
    chk("postrst_pio", pio_data, 32'h0);
    // Key held through reset raises its flag after the second tick
    run(6);
    chk("heldkey_pio", pio_data, 32'h0090_0000);
    chk("heldkey_irq", {31'h0, irq}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/key_sw_capture.md
# key_sw_capture

Input-side companion to the Nios HEX output path. It turns the board's raw push-buttons and slide switches into a clean 32-bit word for a Nios PIO input port. It synchronises and debounces every input, latches key-press events as sticky edge flags, and raises an interrupt until software acknowledges. It sits in the board top level between the KEY/SW pins and the Nios system's input-PIO export.

## Interface
- N_KEYS, 3: user push-buttons (KEY[0] stays the system reset and is not connected here)
- N_SW, 18: slide switches
- DEBOUNCE_CYCLES, 1000000: sample-tick period in clocks (20 ms at 50 MHz); must be ≥ 2
- CNT_W, 20: tick-counter width; 2^CNT_W ≥ DEBOUNCE_CYCLES
- Constraint: N_SW + 2·N_KEYS ≤ 32

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- key_n  in  N_KEYS  raw buttons, active-low, asynchronous
- sw  in  N_SW  raw switches, active-high, asynchronous
- ack  in  1  one-cycle clear strobe from software/PIO
- ack_mask  in  N_KEYS  edge flags to clear when ack=1
- pio_data  out  32  packed status word for the PIO input export
- irq  out  1  high while any edge flag is set

## Operation
- Synchroniser: each key_n and sw bit passes through 2 flops. Keys are inverted after synchronising, so pressed = 1.
- Tick counter:
  - Counts 0..DEBOUNCE_CYCLES-1, then wraps to 0.
  - tick = 1 for the single cycle in which count == DEBOUNCE_CYCLES-1.
- Debounce: on each tick, per input:
  - sample ← synchronised value.
  - If the synchronised value equals the previous sample, deb ← that value. Otherwise deb holds.
  - A change is therefore accepted only after two consecutive agreeing ticks.
- Edge capture, keys only:
  - On a tick where deb_key[i] goes 0→1, edge[i] is set.
  - Release (1→0) sets nothing.
  - Flags are sticky.
- Clear: ack=1 clears each edge[i] whose ack_mask[i]=1. Unmasked bits are unaffected.
- Simultaneous set and clear of the same bit in one cycle: set wins, so no press is ever lost.
- irq = OR of all edge bits, taken directly from the registered flags (glitch-free, no extra stage).
- pio_data packing (defaults in brackets):
  - [N_SW-1:0] = deb_sw [17:0]
  - [N_SW+N_KEYS-1:N_SW] = deb_key [20:18]
  - [N_SW+2·N_KEYS-1:N_SW+N_KEYS] = edge [23:21]
  - remaining bits = 0 [31:24]
  - Registered output; updates the cycle after its source registers change.
- ack with no flags set: no effect.
- ack held high for several cycles: clears on every cycle it is high.

## Timing
- Reset (reset_reset_n=0 at a clock edge): synchroniser flops, samples, deb_*, edge, tick counter, pio_data and irq all become 0 on that edge.
- Reset asserted mid-operation discards pending samples and flags with no residue.
- After reset release:
  - An input that is already static appears on pio_data after the 2nd tick plus 1 cycle.
  - A key held through reset produces an edge flag at that point. This is intentional.
- Input-to-deb latency: 2 sync cycles, then between DEBOUNCE_CYCLES+1 and 2·DEBOUNCE_CYCLES clocks depending on tick phase. pio_data follows 1 cycle later.
- Bounce rule: a pulse or glitch shorter than one tick period, sampled by at most one tick, never changes deb.
- edge[i] and irq rise on the same edge that deb_key[i] rises. The pio_data edge field follows 1 cycle later.
- ack clear: the flag is 0 on the edge where ack is sampled. irq drops in the same cycle if no flags remain.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and CNT_W=3.
1. Reset with all inputs idle (key_n=3'b111, sw=0), run 20 cycles → pio_data=32'h0 and irq=0 throughout.
2. Set sw=18'h2A5A5 and hold → pio_data[17:0]=18'h2A5A5 within 2+8+1 cycles; edge field and irq stay 0.
3. Drive key_n[1]=0 and hold → pio_data[19]=1, pio_data[22]=1 and irq=1. Release the key → bit 19 returns to 0, bit 22 stays 1.
4. Pulse key_n[0]=0 for 3 cycles, placed so only one tick samples it → no change to pio_data and irq stays 0.
5. With edge=3'b101, pulse ack with ack_mask=3'b001 → edge=3'b100 and irq=1. Pulse ack with ack_mask=3'b100 → edge=0 and irq=0 in that same cycle.
6. Arrange a key-2 press to be accepted on the same edge as ack with ack_mask=3'b100 → edge[2] stays 1. Then assert reset mid-count → all outputs are 0 on the next edge.
